// File: rtl/ram_block_mover_if.sv
// Command and RAM-side signal bundle for ram_block_mover.
// slave: the mover itself; master: whoever issues commands and owns the RAM.
interface ram_block_mover_if;
  logic        start;
  logic        op;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  len;
  logic [31:0] fill_data;
  logic        busy;
  logic        done;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_rw;
  logic [31:0] ram_dout;
  logic [8:0]  words_done;

  modport slave (
    input  start, op, src_addr, dst_addr, len, fill_data, ram_dout,
    output busy, done, ram_addr, ram_din, ram_rw, words_done
  );

  modport master (
    output start, op, src_addr, dst_addr, len, fill_data, ram_dout,
    input  busy, done, ram_addr, ram_din, ram_rw, words_done
  );
endinterface

// File: rtl/ram_block_mover.sv
// Block FILL / COPY engine driving a single-port RAM with one-cycle read latency.
// FILL writes one word per cycle; COPY uses read, wait, write (3 cycles per word),
// always in ascending address order so overlapping copies see earlier writes.
module ram_block_mover (
  input  logic             clk,
  input  logic             rst_n,
  ram_block_mover_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StFillWr, StCpRd, StCpWait, StCpWr, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        op_q;
  logic [7:0]  src_q;
  logic [7:0]  dst_q;
  logic [8:0]  len_q;
  logic [31:0] fill_q;
  logic [31:0] data_q;
  logic [8:0]  words_q;

  logic [8:0]  len_clamped;
  logic        accept;
  logic        wr_en;
  logic        last_word;
  logic [7:0]  idx;

  assign len_clamped = (bus.len > 9'd256) ? 9'd256 : bus.len;
  assign accept      = (state_q == StIdle) && bus.start;
  // The written-word count doubles as the word index; it never exceeds 255 while moving.
  assign idx         = words_q[7:0];
  assign last_word   = (words_q + 9'd1) == len_q;

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.words_done = words_q;

  // Next-state and RAM port drive; RAM idles in read with zero address/data.
  always_comb begin
    state_d      = state_q;
    wr_en        = 1'b0;
    bus.ram_addr = 8'd0;
    bus.ram_din  = 32'd0;
    bus.ram_rw   = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (len_clamped == 9'd0) state_d = StDone;
          else if (bus.op)         state_d = StCpRd;
          else                     state_d = StFillWr;
        end
      end
      StFillWr: begin
        bus.ram_addr = dst_q + idx;
        bus.ram_din  = fill_q;
        bus.ram_rw   = 1'b0;
        wr_en        = 1'b1;
        if (last_word) state_d = StDone;
      end
      StCpRd: begin
        bus.ram_addr = src_q + idx;
        state_d      = StCpWait;
      end
      StCpWait: begin
        bus.ram_addr = src_q + idx;
        state_d      = StCpWr;
      end
      StCpWr: begin
        bus.ram_addr = dst_q + idx;
        bus.ram_din  = data_q;
        bus.ram_rw   = 1'b0;
        wr_en        = 1'b1;
        state_d      = last_word ? StDone : StCpRd;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Command latch; only an accepted start in IDLE updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 1'b0;
      src_q  <= 8'd0;
      dst_q  <= 8'd0;
      len_q  <= 9'd0;
      fill_q <= 32'd0;
    end else if (accept) begin
      op_q   <= bus.op;
      src_q  <= bus.src_addr;
      dst_q  <= bus.dst_addr;
      len_q  <= len_clamped;
      fill_q <= bus.fill_data;
    end
  end

  // Read data capture on the edge that ends CP_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   data_q <= 32'd0;
    else if (state_q == StCpWait) data_q <= bus.ram_dout;
  end

  // Written-word counter: cleared on accept, bumped after each write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      words_q <= 9'd0;
    else if (accept) words_q <= 9'd0;
    else if (wr_en)  words_q <= words_q + 9'd1;
  end

endmodule
